lcd_ram_arbiter: RTL and testbench

- Shares the single-port 160x132 image RAM between two requesters:
  - the LCD refresh reader (display port);
  - a host write port that updates image rows at run time.
- Issues at most one RAM access per cycle and drives the RAM's ClockEn, WE, Address and Data pins.
- Returns read data to the display port with a valid strobe.
- Display has fixed priority. A starvation guard gives the host bounded access.

---
 rtl/lcd_ram_arbiter_pkg.sv | 24 ++
 rtl/lcd_ram_arbiter_if.sv | 39 +++
 rtl/lcd_ram_rd_pipe.sv | 36 +++
 rtl/lcd_ram_arbiter.sv | 170 +++++++++++++++++
 tb/tb_lcd_ram_arbiter.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_ram_arbiter_pkg.sv
// Shared defaults, arbiter state encoding and a counter-width helper.
// No logic; imported by the interface, the read pipe and the arbiter.
// No backpressure of its own.
package lcd_ram_arbiter_pkg;

    localparam int LCD_ADDR_W     = 8;
    localparam int LCD_DATA_W     = 132;
    localparam int LCD_DEPTH      = 160;
    localparam int LCD_RD_LAT     = 1;
    localparam int LCD_MAX_WAIT   = 15;
    localparam int LCD_HOST_BURST = 4;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_DISP = 2'd1,
        ARB_HOST = 2'd2
    } arb_state_t;

    // Bits needed to hold 0..max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/lcd_ram_arbiter_if.sv
// Display/host request ports and image RAM pins of the LCD RAM arbiter.
// Grants are same-cycle; RAM pins are registered one cycle after grant.
// Requesters hold request and address until they see their grant.
interface lcd_ram_arbiter_if import lcd_ram_arbiter_pkg::*; #(
    parameter int ADDR_W = LCD_ADDR_W,
    parameter int DATA_W = LCD_DATA_W
);
    logic              disp_req_in;
    logic [ADDR_W-1:0] disp_addr_in;
    logic              disp_gnt_out;
    logic [DATA_W-1:0] disp_data_out;
    logic              disp_valid_out;

    logic              host_req_in;
    logic [ADDR_W-1:0] host_addr_in;
    logic [DATA_W-1:0] host_data_in;
    logic              host_gnt_out;

    logic              addr_err_out;

    logic              ram_clk_en_out;
    logic              ram_we_out;
    logic [ADDR_W-1:0] ram_addr_out;
    logic [DATA_W-1:0] ram_data_out;
    logic [DATA_W-1:0] ram_q_in;

    modport slave (
        input  disp_req_in, disp_addr_in, host_req_in, host_addr_in, host_data_in, ram_q_in,
        output disp_gnt_out, disp_data_out, disp_valid_out, host_gnt_out, addr_err_out,
        output ram_clk_en_out, ram_we_out, ram_addr_out, ram_data_out
    );

    modport master (
        output disp_req_in, disp_addr_in, host_req_in, host_addr_in, host_data_in, ram_q_in,
        input  disp_gnt_out, disp_data_out, disp_valid_out, host_gnt_out, addr_err_out,
        input  ram_clk_en_out, ram_we_out, ram_addr_out, ram_data_out
    );

endinterface

// File: rtl/lcd_ram_rd_pipe.sv
// Tracks issued display reads and captures RAM Q into a registered output.
// Latency: valid/data out 2+RD_LAT cycles after issue_vld is presented.
// No backpressure: the display port must accept every strobe.
module lcd_ram_rd_pipe #(
    parameter int DATA_W = 132,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue_vld,
    input  logic [DATA_W-1:0] ram_q,
    output logic              out_vld,
    output logic [DATA_W-1:0] out_dat
);

    // Stage 0 lines up with the registered RAM access, stage RD_LAT with valid Q.
    logic [RD_LAT:0] vld_sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_sr  <= '0;
            out_vld <= 1'b0;
            out_dat <= '0;
        end else begin
            vld_sr[0] <= issue_vld;
            for (int i = 1; i <= RD_LAT; i++) begin
                vld_sr[i] <= vld_sr[i-1];
            end
            out_vld <= vld_sr[RD_LAT];
            if (vld_sr[RD_LAT]) begin
                out_dat <= ram_q;
            end
        end
    end

endmodule

// File: rtl/lcd_ram_arbiter.sv
// Shares the single-port image RAM between LCD refresh reads and host row writes.
// Same-cycle grant, RAM pins registered next cycle, read data valid 2+RD_LAT after grant.
// Display has fixed priority; a wait counter forces bounded host bursts. LCD_RAM_FRAME_LOCK_EN holds the host off mid-frame.
module lcd_ram_arbiter import lcd_ram_arbiter_pkg::*; #(
    parameter int ADDR_W     = LCD_ADDR_W,
    parameter int DATA_W     = LCD_DATA_W,
    parameter int DEPTH      = LCD_DEPTH,
    parameter int RD_LAT     = LCD_RD_LAT,
    parameter int MAX_WAIT   = LCD_MAX_WAIT,
    parameter int HOST_BURST = LCD_HOST_BURST
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    lcd_ram_arbiter_if.slave  bus
);

    localparam int WAIT_W  = cnt_width(MAX_WAIT);
    localparam int BURST_W = cnt_width(HOST_BURST);

    localparam logic [ADDR_W:0]    DEPTH_V     = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0]  LAST_ADDR   = ADDR_W'(DEPTH - 1);
    localparam logic [WAIT_W-1:0]  WAIT_MAX_V  = WAIT_W'(MAX_WAIT);
    localparam logic [BURST_W-1:0] BURST_MAX_V = BURST_W'(HOST_BURST);

    arb_state_t          state_q;
    arb_state_t          state_d;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [BURST_W-1:0]  burst_cnt;
    logic [BURST_W-1:0]  burst_d;

    logic                disp_gnt_raw;
    logic                host_gnt_raw;
    logic                disp_gnt;
    logic                host_gnt;
    logic                disp_legal;
    logic                host_legal;
    logic                host_block;
    logic                guard_fire;
    logic                disp_issue;
    logic                host_issue;

    logic                ram_clk_en_q;
    logic                ram_we_q;
    logic [ADDR_W-1:0]   ram_addr_q;
    logic [DATA_W-1:0]   ram_data_q;
    logic                addr_err_q;
    logic                rd_vld;
    logic [DATA_W-1:0]   rd_dat;

    assign disp_legal = {1'b0, bus.disp_addr_in} < DEPTH_V;
    assign host_legal = {1'b0, bus.host_addr_in} < DEPTH_V;

`ifdef LCD_RAM_FRAME_LOCK_EN
    // Set by the first row of a refresh, cleared by the last, so host writes never tear a frame.
    logic frame_active;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            frame_active <= 1'b0;
        end else if (disp_gnt) begin
            if (bus.disp_addr_in == '0) begin
                frame_active <= 1'b1;
            end else if (bus.disp_addr_in == LAST_ADDR) begin
                frame_active <= 1'b0;
            end
        end
    end

    assign host_block = frame_active;
`else
    assign host_block = 1'b0;
`endif

    assign guard_fire = bus.host_req_in && (wait_cnt == WAIT_MAX_V) && !host_block;

    always_comb begin
        state_d      = state_q;
        burst_d      = burst_cnt;
        disp_gnt_raw = 1'b0;
        host_gnt_raw = 1'b0;
        if (state_q == ARB_HOST && bus.host_req_in && burst_cnt < BURST_MAX_V) begin
            host_gnt_raw = 1'b1;
            burst_d      = burst_cnt + 1'b1;
        end else begin
            // Burst exhausted or idle: normal display-priority arbitration this same cycle.
            burst_d = '0;
            if (guard_fire) begin
                host_gnt_raw = 1'b1;
                burst_d      = BURST_W'(1);
                state_d      = ARB_HOST;
            end else if (bus.disp_req_in) begin
                disp_gnt_raw = 1'b1;
                state_d      = ARB_DISP;
            end else if (bus.host_req_in && !host_block) begin
                host_gnt_raw = 1'b1;
                state_d      = ARB_IDLE;
            end else begin
                state_d = ARB_IDLE;
            end
        end
    end

    // Grants are combinational, so they are also forced low while reset is held.
    assign disp_gnt   = disp_gnt_raw & rst_n_in;
    assign host_gnt   = host_gnt_raw & rst_n_in;
    assign disp_issue = disp_gnt & disp_legal;
    assign host_issue = host_gnt & host_legal;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q   <= ARB_IDLE;
            burst_cnt <= '0;
            wait_cnt  <= '0;
        end else begin
            state_q   <= state_d;
            burst_cnt <= burst_d;
            if (!bus.host_req_in || host_gnt) begin
                wait_cnt <= '0;
            end else if (wait_cnt != WAIT_MAX_V) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            ram_clk_en_q <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_data_q   <= '0;
            addr_err_q   <= 1'b0;
        end else begin
            ram_clk_en_q <= disp_issue | host_issue;
            ram_we_q     <= host_issue;
            if (disp_issue) begin
                ram_addr_q <= bus.disp_addr_in;
            end else if (host_issue) begin
                ram_addr_q <= bus.host_addr_in;
                ram_data_q <= bus.host_data_in;
            end
            // Illegal rows are consumed without touching the RAM; the flag is sticky.
            if ((disp_gnt && !disp_legal) || (host_gnt && !host_legal)) begin
                addr_err_q <= 1'b1;
            end
        end
    end

    lcd_ram_rd_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk       (clk_in),
        .rst_n     (rst_n_in),
        .issue_vld (disp_issue),
        .ram_q     (bus.ram_q_in),
        .out_vld   (rd_vld),
        .out_dat   (rd_dat)
    );

    assign bus.disp_gnt_out   = disp_gnt;
    assign bus.host_gnt_out   = host_gnt;
    assign bus.disp_valid_out = rd_vld;
    assign bus.disp_data_out  = rd_dat;
    assign bus.addr_err_out   = addr_err_q;
    assign bus.ram_clk_en_out = ram_clk_en_q;
    assign bus.ram_we_out     = ram_we_q;
    assign bus.ram_addr_out   = ram_addr_q;
    assign bus.ram_data_out   = ram_data_q;

endmodule

// File: tb/tb_lcd_ram_arbiter.sv
// Self-checking bench for lcd_ram_arbiter: vector table, scoreboard on read data, corner sequences.
// Build with LCD_RAM_FRAME_LOCK_EN defined to also run the frame-lock sequence.
module tb_lcd_ram_arbiter;
    import lcd_ram_arbiter_pkg::*;

    localparam int AW    = LCD_ADDR_W;
    localparam int DW    = LCD_DATA_W;
    localparam int DEPTH = LCD_DEPTH;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic preload = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lcd_ram_arbiter_if bus();

    lcd_ram_arbiter dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus)
    );

    function automatic logic [DW-1:0] row_pat(input int i);
        return {4'hC, 32'(i * 32'h9E3779B9), 32'(i), ~32'(i), 32'(i) ^ 32'h5A5A5A5A};
    endfunction

    // RAM model: registered access, Q valid one cycle after the access cycle.
    logic [DW-1:0] ram_mem [DEPTH];
    logic [DW-1:0] ram_q = '0;
    assign bus.ram_q_in = ram_q;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < DEPTH; i++) ram_mem[i] <= row_pat(i);
        end else if (bus.ram_clk_en_out) begin
            if (bus.ram_we_out) ram_mem[bus.ram_addr_out] <= bus.ram_data_out;
            else ram_q <= ram_mem[bus.ram_addr_out];
        end
    end

    int n_cmp = 0;
    int n_bad = 0;
    int n_vld = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: expected row and due cycle pushed at grant, popped on each valid strobe.
    typedef struct {
        logic [DW-1:0] dat;
        int            due;
    } exp_t;
    exp_t sb[$];
    logic [DW-1:0] ref_mem [DEPTH];

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            sb.delete();
            if (preload) for (int i = 0; i < DEPTH; i++) ref_mem[i] = row_pat(i);
        end else begin
            check("gnt_exclusive", DW'(bus.disp_gnt_out & bus.host_gnt_out), '0);
            if (bus.disp_valid_out) begin
                n_vld++;
                if (sb.size() == 0) begin
                    check("unexpected_valid", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("rd_data", bus.disp_data_out, e.dat);
                    check("rd_latency", DW'(cyc), DW'(e.due));
                end
            end
            if (bus.disp_gnt_out && int'(bus.disp_addr_in) < DEPTH) begin
                e.dat = ref_mem[bus.disp_addr_in];
                e.due = cyc + 3;
                sb.push_back(e);
            end
            if (bus.host_gnt_out && int'(bus.host_addr_in) < DEPTH)
                ref_mem[bus.host_addr_in] = bus.host_data_in;
        end
    end

    task automatic drive(input logic dr, input logic [AW-1:0] da, input logic hr,
                         input logic [AW-1:0] ha, input logic [DW-1:0] hd);
        bus.disp_req_in  = dr;
        bus.disp_addr_in = da;
        bus.host_req_in  = hr;
        bus.host_addr_in = ha;
        bus.host_data_in = hd;
    endtask

    task automatic next_drive(input logic dr, input logic [AW-1:0] da, input logic hr,
                              input logic [AW-1:0] ha, input logic [DW-1:0] hd);
        @(posedge clk);
        #1;
        drive(dr, da, hr, ha, hd);
    endtask

    task automatic idle(input int n);
        next_drive(0, '0, 0, '0, '0);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        next_drive(0, '0, 0, '0, '0);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    typedef struct {
        logic          dr;
        logic [AW-1:0] da;
        logic          hr;
        logic [AW-1:0] ha;
        logic [DW-1:0] hd;
        logic          e_dg;
        logic          e_hg;
        logic          e_en;
        logic          e_we;
        logic [AW-1:0] e_addr;
    } vec_t;

    vec_t tbl [7];

    int ngnt, nv0, waits, burst, last_cyc, host_cyc, ptr;
    logic got, done;

    initial begin
        tbl[0] = '{1'b1, 8'd3,   1'b0, 8'd0,   '0,                       1'b1, 1'b0, 1'b1, 1'b0, 8'd3};
        tbl[1] = '{1'b0, 8'd0,   1'b1, 8'd7,   132'h77,                  1'b0, 1'b1, 1'b1, 1'b1, 8'd7};
        tbl[2] = '{1'b1, 8'd9,   1'b1, 8'd12,  132'h1234,                1'b1, 1'b0, 1'b1, 1'b0, 8'd9};
        tbl[3] = '{1'b0, 8'd0,   1'b0, 8'd0,   '0,                       1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[4] = '{1'b1, 8'd159, 1'b0, 8'd0,   '0,                       1'b1, 1'b0, 1'b1, 1'b0, 8'd159};
        tbl[5] = '{1'b0, 8'd0,   1'b1, 8'd159, {4'h3, 128'hDEAD_BEEF},   1'b0, 1'b1, 1'b1, 1'b1, 8'd159};
        tbl[6] = '{1'b1, 8'd159, 1'b0, 8'd0,   '0,                       1'b1, 1'b0, 1'b1, 1'b0, 8'd159};

        // Reset state, with a display request present to show grants are held low.
        drive(1, 8'd3, 1, 8'd4, '1);
        #12;
        check("rst_disp_gnt",  bus.disp_gnt_out,   0);
        check("rst_host_gnt",  bus.host_gnt_out,   0);
        check("rst_valid",     bus.disp_valid_out, 0);
        check("rst_data",      bus.disp_data_out,  0);
        check("rst_addr_err",  bus.addr_err_out,   0);
        check("rst_clk_en",    bus.ram_clk_en_out, 0);
        check("rst_we",        bus.ram_we_out,     0);
        check("rst_ram_addr",  bus.ram_addr_out,   0);
        check("rst_ram_data",  bus.ram_data_out,   0);
        drive(0, '0, 0, '0, '0);
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
        preload = 1'b0;

        // Single-cycle vectors, each followed by an idle cycle that shows the RAM pins.
        for (int i = 0; i < 7; i++) begin
            next_drive(tbl[i].dr, tbl[i].da, tbl[i].hr, tbl[i].ha, tbl[i].hd);
            @(negedge clk);
            check($sformatf("vec%0d_disp_gnt", i), bus.disp_gnt_out, tbl[i].e_dg);
            check($sformatf("vec%0d_host_gnt", i), bus.host_gnt_out, tbl[i].e_hg);
            next_drive(0, '0, 0, '0, '0);
            @(negedge clk);
            check($sformatf("vec%0d_clk_en", i), bus.ram_clk_en_out, tbl[i].e_en);
            check($sformatf("vec%0d_we", i), bus.ram_we_out, tbl[i].e_we);
            if (tbl[i].e_en) check($sformatf("vec%0d_addr", i), bus.ram_addr_out, tbl[i].e_addr);
            if (tbl[i].e_we) check($sformatf("vec%0d_wdata", i), bus.ram_data_out, tbl[i].hd);
        end
        idle(4);
        check("vec_addr_err", bus.addr_err_out, 0);

        // Full refresh 0..159 back to back.
        nv0 = n_vld;
        ngnt = 0;
        for (int a = 0; a < DEPTH; a++) begin
            next_drive(1, AW'(a), 0, '0, '0);
            @(negedge clk);
            if (bus.disp_gnt_out) ngnt++;
        end
        idle(6);
        check("stream_gnts", DW'(ngnt), DW'(DEPTH));
        check("stream_vlds", DW'(n_vld - nv0), DW'(DEPTH));

        // Host write of row 5, then read back.
        next_drive(0, '0, 1, 8'd5, 132'hA5);
        @(negedge clk);
        check("hw_gnt", bus.host_gnt_out, 1);
        next_drive(0, '0, 0, '0, '0);
        @(negedge clk);
        check("hw_we", bus.ram_we_out, 1);
        check("hw_addr", bus.ram_addr_out, 5);
        check("hw_data", bus.ram_data_out, 132'hA5);
        nv0 = n_vld;
        next_drive(1, 8'd5, 0, '0, '0);
        idle(5);
        check("hw_readback_vld", DW'(n_vld - nv0), 1);

        // Starvation guard against a continuous display stream.
        waits = 0;
        got = 1'b0;
        for (int k = 0; k < 100 && !got; k++) begin
            next_drive(1, AW'(20 + k), 1, 8'd10, 132'hBEEF + DW'(k));
            @(negedge clk);
            if (bus.host_gnt_out) got = 1'b1;
            else waits++;
        end
        check("starve_granted", DW'(got), 1);
        check("starve_wait", DW'(waits), 15);
        burst = got ? 1 : 0;
        done = 1'b0;
        for (int k = 0; k < 10 && !done; k++) begin
            next_drive(1, AW'(130 + k), 1, 8'd10, 132'hCAFE + DW'(k));
            @(negedge clk);
            if (bus.host_gnt_out) burst++;
            else begin
                done = 1'b1;
                check("burst_resume_disp", bus.disp_gnt_out, 1);
            end
        end
        check("burst_len", DW'(burst), 4);
        idle(6);

        // Illegal addresses: consumed, no RAM access, no strobe, sticky error.
        nv0 = n_vld;
        next_drive(1, 8'd200, 0, '0, '0);
        @(negedge clk);
        check("ill_disp_gnt", bus.disp_gnt_out, 1);
        next_drive(0, '0, 1, 8'd170, '1);
        @(negedge clk);
        check("ill_clk_en_disp", bus.ram_clk_en_out, 0);
        check("ill_err_set", bus.addr_err_out, 1);
        check("ill_host_gnt", bus.host_gnt_out, 1);
        next_drive(0, '0, 0, '0, '0);
        @(negedge clk);
        check("ill_clk_en_host", bus.ram_clk_en_out, 0);
        idle(6);
        check("ill_no_vld", DW'(n_vld - nv0), 0);
        check("ill_err_sticky", bus.addr_err_out, 1);
        do_reset();
        @(negedge clk);
        check("ill_err_cleared", bus.addr_err_out, 0);

        // Asynchronous reset one cycle after a display grant drops the read.
        next_drive(1, 8'd7, 0, '0, '0);
        @(negedge clk);
        check("ar_gnt", bus.disp_gnt_out, 1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("ar_clk_en", bus.ram_clk_en_out, 0);
        check("ar_ram_addr", bus.ram_addr_out, 0);
        check("ar_disp_gnt", bus.disp_gnt_out, 0);
        drive(0, '0, 0, '0, '0);
        nv0 = n_vld;
        @(negedge clk);
        #1 rst_n = 1'b1;
        idle(6);
        check("ar_no_vld", DW'(n_vld - nv0), 0);

`ifdef LCD_RAM_FRAME_LOCK_EN
        // Host requesting mid-frame waits until the row after DEPTH-1 is granted.
        do_reset();
        ptr = 0;
        last_cyc = -100;
        host_cyc = -1;
        for (int k = 0; k < 400 && host_cyc < 0; k++) begin
            next_drive(1, AW'(ptr), (ptr >= 50) || (last_cyc > 0), 8'd30, 132'hF00D);
            @(negedge clk);
            if (bus.host_gnt_out) host_cyc = cyc;
            if (bus.disp_gnt_out) begin
                if (ptr == DEPTH - 1) last_cyc = cyc;
                ptr = (ptr + 1) % DEPTH;
            end
        end
        check("lock_host_after_frame", DW'(host_cyc), DW'(last_cyc + 1));
        idle(8);
`endif

        idle(4);
        check("sb_drained", DW'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
